// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM host-port arbiter: FSM state encodings,
// byte-select constants and default bus widths.
package sdram_pkg;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 16;

  localparam logic [1:0] BYTESEL_NONE = 2'b00;
  localparam logic [1:0] BYTESEL_WORD = 2'b11;

  typedef enum logic [1:0] {
    ARB_INIT    = 2'b00,
    ARB_IDLE    = 2'b01,
    ARB_GRANT   = 2'b11,
    ARB_RELEASE = 2'b10
  } arb_state_t;

  // A requester signals a pending transaction by driving any byte lane.
  function automatic logic is_req(input logic [1:0] bytesel);
    return bytesel != BYTESEL_NONE;
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational two-way selector: round-robin against the last served port,
// or fixed priority to port 0 when 'fixed' is set.
module sdram_rr_pick
  import sdram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic       gnt,
  output logic       valid
);

  always_comb begin
    valid = |req;
    gnt   = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = fixed ? 1'b0 : ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares the single sdram_controller host port between two requesters,
// waiting for controller initialisation and routing completions back.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_wr_en,
  input  logic [1:0]            m0_bytesel,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_compl,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_wr_en,
  input  logic [1:0]            m1_bytesel,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_compl,
  output logic [ADDR_WIDTH-1:0] h_addr,
  output logic                  h_wr_en,
  output logic [1:0]            h_bytesel,
  output logic [DATA_WIDTH-1:0] h_wdata,
  input  logic [DATA_WIDTH-1:0] h_rdata,
  input  logic                  h_compl,
  output logic                  init_done
);

  arb_state_t state;
  logic       gnt;
  logic       last;
  logic [1:0] req;
  logic       pick_gnt;
  logic       pick_valid;

  assign req = {is_req(m1_bytesel), is_req(m0_bytesel)};

  sdram_rr_pick u_pick (
    .req   (req),
    .last  (last),
    .fixed (FIXED_PRIO != 0),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_INIT;
      gnt       <= 1'b0;
      last      <= 1'b1;
      init_done <= 1'b0;
    end else begin
      case (state)
        ARB_INIT: begin
          if (h_compl) begin
            state     <= ARB_IDLE;
            init_done <= 1'b1;
          end
        end
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt   <= pick_gnt;
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (h_compl) begin
            last  <= gnt;
            state <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: state <= ARB_IDLE;
        default:     state <= ARB_INIT;
      endcase
    end
  end

  // Byte lanes drop in the completion cycle so the controller never sees a
  // second command start before the release cycle.
  always_comb begin
    h_addr    = '0;
    h_wr_en   = 1'b0;
    h_wdata   = '0;
    h_bytesel = BYTESEL_NONE;
    m0_compl  = 1'b0;
    m1_compl  = 1'b0;
    if (state == ARB_GRANT) begin
      if (gnt) begin
        h_addr    = m1_addr;
        h_wr_en   = m1_wr_en;
        h_wdata   = m1_wdata;
        h_bytesel = h_compl ? BYTESEL_NONE : m1_bytesel;
        m1_compl  = h_compl;
      end else begin
        h_addr    = m0_addr;
        h_wr_en   = m0_wr_en;
        h_wdata   = m0_wdata;
        h_bytesel = h_compl ? BYTESEL_NONE : m0_bytesel;
        m0_compl  = h_compl;
      end
    end
  end

  assign m0_rdata = h_rdata;
  assign m1_rdata = h_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a round-robin instance behind a small
// controller/memory model, plus a fixed-priority instance for tie-break order.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [1:0]  bs;
  } host_t;

  typedef struct {
    int          port;
    bit          chk;
    logic [15:0] rdata;
  } compl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init_pulse;
  logic [31:0] req_addr  [4];
  logic        req_wr    [4];
  logic [1:0]  req_bs    [4];
  logic [15:0] req_wdata [4];

  logic [15:0] m0_rdata, m1_rdata, h_wdata, h_rdata;
  logic        m0_compl, m1_compl, h_wr_en, h_compl, init_done;
  logic [31:0] h_addr;
  logic [1:0]  h_bytesel;

  logic [15:0] f0_rdata, f1_rdata, hf_wdata, hf_rdata;
  logic        f0_compl, f1_compl, hf_wr_en, hf_compl, f_init_done;
  logic [31:0] hf_addr;
  logic [1:0]  hf_bytesel;

  logic [3:0]  compl_v;
  logic        auto_compl = 1'b0;
  logic        auto_compl1 = 1'b0;

  host_t       hq[$];
  compl_t      cq[$];
  int          fq[$];
  logic [15:0] mem [logic [15:0]];

  int n_checks = 0;
  int n_fail = 0;

  assign h_compl  = init_pulse | auto_compl;
  assign hf_compl = init_pulse | auto_compl1;
  assign hf_rdata = 16'h0000;
  assign compl_v  = {f1_compl, f0_compl, m1_compl, m0_compl};

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(req_addr[0]), .m0_wr_en(req_wr[0]), .m0_bytesel(req_bs[0]),
    .m0_wdata(req_wdata[0]), .m0_rdata(m0_rdata), .m0_compl(m0_compl),
    .m1_addr(req_addr[1]), .m1_wr_en(req_wr[1]), .m1_bytesel(req_bs[1]),
    .m1_wdata(req_wdata[1]), .m1_rdata(m1_rdata), .m1_compl(m1_compl),
    .h_addr(h_addr), .h_wr_en(h_wr_en), .h_bytesel(h_bytesel), .h_wdata(h_wdata),
    .h_rdata(h_rdata), .h_compl(h_compl), .init_done(init_done)
  );

  sdram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(16), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(req_addr[2]), .m0_wr_en(req_wr[2]), .m0_bytesel(req_bs[2]),
    .m0_wdata(req_wdata[2]), .m0_rdata(f0_rdata), .m0_compl(f0_compl),
    .m1_addr(req_addr[3]), .m1_wr_en(req_wr[3]), .m1_bytesel(req_bs[3]),
    .m1_wdata(req_wdata[3]), .m1_rdata(f1_rdata), .m1_compl(f1_compl),
    .h_addr(hf_addr), .h_wr_en(hf_wr_en), .h_bytesel(hf_bytesel), .h_wdata(hf_wdata),
    .h_rdata(hf_rdata), .h_compl(hf_compl), .init_done(f_init_done)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input int port, input logic [31:0] a, input logic w, input logic [15:0] d,
                            input logic [1:0] bs, input bit chk, input logic [15:0] rd);
    host_t  h;
    compl_t c;
    h.addr = a; h.wr = w; h.wdata = d; h.bs = bs;
    c.port = port; c.chk = chk; c.rdata = rd;
    hq.push_back(h);
    cq.push_back(c);
  endtask

  // Requester: hold the transaction until its completion, then optionally drop.
  task automatic apply_stimulus(input int p, input logic [31:0] a, input logic w, input logic [15:0] d,
                                input logic [1:0] bs, input bit drop);
    bit got;
    got = 1'b0;
    req_addr[p] = a; req_wr[p] = w; req_wdata[p] = d; req_bs[p] = bs;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = compl_v[p];
    end
    check_output("txn_completed", got, 1);
    @(posedge clk);
    #1;
    if (drop || !got) req_bs[p] = BYTESEL_NONE;
  endtask

  // Controller models: complete a command two cycles after its byte lanes appear.
  logic [1:0]  s_bs = 2'b00, s_bs1 = 2'b00;
  logic        s_wr;
  logic [31:0] s_addr;
  logic [15:0] s_wdata;
  int          wait_cnt = 0, wait_cnt1 = 0;

  initial h_rdata = 16'h0000;

  always @(negedge clk) begin
    s_bs = h_bytesel; s_wr = h_wr_en; s_addr = h_addr; s_wdata = h_wdata;
    s_bs1 = hf_bytesel;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      wait_cnt = 0; auto_compl = 1'b0;
    end else if (auto_compl) begin
      auto_compl = 1'b0;
    end else if (s_bs != 2'b00) begin
      wait_cnt++;
      if (wait_cnt == 2) begin
        wait_cnt = 0;
        auto_compl = 1'b1;
        if (s_wr) mem[s_addr[15:0]] = s_wdata;
        else h_rdata = mem.exists(s_addr[15:0]) ? mem[s_addr[15:0]] : 16'h0000;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      wait_cnt1 = 0; auto_compl1 = 1'b0;
    end else if (auto_compl1) begin
      auto_compl1 = 1'b0;
    end else if (s_bs1 != 2'b00) begin
      wait_cnt1++;
      if (wait_cnt1 == 2) begin
        wait_cnt1 = 0;
        auto_compl1 = 1'b1;
      end
    end else begin
      wait_cnt1 = 0;
    end
  end

  // Monitor for the round-robin instance: host commands and completions.
  int     zero_run = 100;
  host_t  he;
  compl_t ce;

  always @(negedge clk) begin
    if (m0_compl || m1_compl) begin
      check_output("compl_onehot", m0_compl & m1_compl, 0);
      check_output("rdata_mirror", {m1_rdata, m0_rdata}, {h_rdata, h_rdata});
      if (cq.size() == 0) begin
        check_output("unexpected_compl", {m1_compl, m0_compl}, 0);
      end else begin
        ce = cq.pop_front();
        check_output("compl_port", {m1_compl, m0_compl}, (ce.port == 1) ? 2'b10 : 2'b01);
        if (ce.chk) check_output("rdata", m1_compl ? m1_rdata : m0_rdata, ce.rdata);
      end
    end
    if (h_bytesel != 2'b00) begin
      if (zero_run > 0) begin
        check_output("release_gap", zero_run >= 3, 1);
        if (hq.size() == 0) begin
          check_output("unexpected_cmd", h_addr, 0);
        end else begin
          he = hq.pop_front();
          check_output("h_addr", h_addr, he.addr);
          check_output("h_wr_en", h_wr_en, he.wr);
          check_output("h_wdata", h_wdata, he.wdata);
          check_output("h_bytesel", h_bytesel, he.bs);
        end
      end
      zero_run = 0;
    end else begin
      zero_run++;
    end
  end

  // Monitor for the fixed-priority instance: grant order and lone-port grants.
  int         fp;
  logic [1:0] f_prev = 2'b00;

  always @(negedge clk) begin
    if (f0_compl || f1_compl) begin
      check_output("f_rdata", {f1_rdata, f0_rdata}, {hf_rdata, hf_rdata});
      if (fq.size() == 0) begin
        check_output("f_unexpected_compl", {f1_compl, f0_compl}, 0);
      end else begin
        fp = fq.pop_front();
        check_output("f_grant_port", {f1_compl, f0_compl}, (fp == 1) ? 2'b10 : 2'b01);
      end
    end
    if (hf_bytesel != 2'b00 && f_prev == 2'b00) begin
      check_output("f_wr_en", hf_wr_en, 0);
      check_output("f_wdata", hf_wdata, (hf_addr == 32'h300) ? req_wdata[3] : req_wdata[2]);
      if (hf_addr == 32'h300) check_output("f_p1_alone", req_bs[2], BYTESEL_NONE);
    end
    f_prev = hf_bytesel;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] a;
    rst_n = 1'b0;
    init_pulse = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = '0; req_wr[i] = 1'b0; req_bs[i] = 2'b00; req_wdata[i] = '0;
    end

    // Reset values, then a request during INIT that must wait for init.
    tick(3);
    check_output("rst_init_done", init_done, 0);
    check_output("rst_bytesel", h_bytesel, 0);
    check_output("rst_addr", h_addr, 0);
    check_output("rst_compl", {m1_compl, m0_compl}, 0);
    rst_n = 1'b1;
    $display("[TB] init phase");
    expect_txn(0, 32'h40, 1'b1, 16'h0041, BYTESEL_WORD, 1'b0, 16'h0);
    fork
      begin
        tick(2);
        apply_stimulus(0, 32'h40, 1'b1, 16'h0041, BYTESEL_WORD, 1'b1);
      end
      begin
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          check_output("init_hold_bytesel", h_bytesel, 0);
          check_output("init_done_low", init_done, 0);
        end
        @(posedge clk); #1 init_pulse = 1'b1;
        @(negedge clk);
        check_output("init_pulse_no_compl", {m1_compl, m0_compl}, 0);
        check_output("init_done_before_edge", init_done, 0);
        @(posedge clk); #1 init_pulse = 1'b0;
        @(negedge clk);
        check_output("init_done_set", init_done, 1);
        check_output("f_init_done_set", f_init_done, 1);
        check_output("idle_bytesel", h_bytesel, 0);
        @(negedge clk);
        check_output("post_init_grant", h_bytesel, BYTESEL_WORD);
      end
    join

    // Single m0 write: forwarded one cycle after the request.
    tick(2);
    $display("[TB] m0 write");
    expect_txn(0, 32'h10, 1'b1, 16'h0011, BYTESEL_WORD, 1'b0, 16'h0);
    fork
      apply_stimulus(0, 32'h10, 1'b1, 16'h0011, BYTESEL_WORD, 1'b1);
      begin
        @(negedge clk);
        check_output("lat_idle", h_bytesel, 0);
        @(negedge clk);
        check_output("lat_grant", h_bytesel, BYTESEL_WORD);
        check_output("lat_addr", h_addr, 32'h10);
        check_output("lat_wr_en", h_wr_en, 1);
        check_output("lat_wdata", h_wdata, 16'h0011);
      end
    join

    tick(2);
    expect_txn(1, 32'h20, 1'b1, 16'h0021, 2'b01, 1'b0, 16'h0);
    apply_stimulus(1, 32'h20, 1'b1, 16'h0021, 2'b01, 1'b1);

    // A stray controller completion in IDLE is ignored.
    tick(2);
    init_pulse = 1'b1;
    @(negedge clk);
    check_output("idle_compl_ignored", {m1_compl, m0_compl}, 0);
    tick(1);
    init_pulse = 1'b0;
    @(negedge clk);
    check_output("idle_compl_bytesel", h_bytesel, 0);
    check_output("idle_init_done", init_done, 1);

    // Both ports continuously reading, last served was port 1.
    tick(2);
    $display("[TB] round-robin");
    expect_txn(0, 32'h10, 1'b0, 16'haaaa, BYTESEL_WORD, 1'b1, 16'h0011);
    expect_txn(1, 32'h20, 1'b0, 16'hbbbb, BYTESEL_WORD, 1'b1, 16'h0021);
    expect_txn(0, 32'h10, 1'b0, 16'haaaa, BYTESEL_WORD, 1'b1, 16'h0011);
    expect_txn(1, 32'h20, 1'b0, 16'hbbbb, BYTESEL_WORD, 1'b1, 16'h0021);
    fork
      begin
        apply_stimulus(0, 32'h10, 1'b0, 16'haaaa, BYTESEL_WORD, 1'b0);
        apply_stimulus(0, 32'h10, 1'b0, 16'haaaa, BYTESEL_WORD, 1'b1);
      end
      begin
        apply_stimulus(1, 32'h20, 1'b0, 16'hbbbb, BYTESEL_WORD, 1'b0);
        apply_stimulus(1, 32'h20, 1'b0, 16'hbbbb, BYTESEL_WORD, 1'b1);
      end
    join

    // Fixed priority: port 0 wins every tie.
    tick(2);
    $display("[TB] fixed priority");
    fq.push_back(0); fq.push_back(0); fq.push_back(0); fq.push_back(1);
    fork
      begin
        apply_stimulus(2, 32'h100, 1'b0, 16'h0c0c, BYTESEL_WORD, 1'b0);
        apply_stimulus(2, 32'h100, 1'b0, 16'h0c0c, BYTESEL_WORD, 1'b0);
        apply_stimulus(2, 32'h100, 1'b0, 16'h0c0c, BYTESEL_WORD, 1'b1);
      end
      apply_stimulus(3, 32'h300, 1'b0, 16'h3c3c, BYTESEL_WORD, 1'b1);
    join

    // Write addr+1 across the address range from m0, read back from m1.
    tick(2);
    $display("[TB] sweep");
    for (int i = 0; i < 16; i++) begin
      a = (i == 15) ? 16'hfffe : 16'(i * 16'h1111);
      expect_txn(0, {16'h0, a}, 1'b1, a + 16'h1, BYTESEL_WORD, 1'b0, 16'h0);
      apply_stimulus(0, {16'h0, a}, 1'b1, a + 16'h1, BYTESEL_WORD, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      a = (i == 15) ? 16'hfffe : 16'(i * 16'h1111);
      expect_txn(1, {16'h0, a}, 1'b0, 16'h0, BYTESEL_WORD, 1'b1, a + 16'h1);
      apply_stimulus(1, {16'h0, a}, 1'b0, 16'h0, BYTESEL_WORD, 1'b1);
    end

    // Serve m0 so last=0, then reset in the middle of an m0 grant.
    expect_txn(0, 32'h50, 1'b1, 16'h0051, BYTESEL_WORD, 1'b0, 16'h0);
    apply_stimulus(0, 32'h50, 1'b1, 16'h0051, BYTESEL_WORD, 1'b1);
    $display("[TB] reset during grant");
    he.addr = 32'h1111; he.wr = 1'b0; he.wdata = 16'h5555; he.bs = BYTESEL_WORD;
    hq.push_back(he);
    expect_txn(0, 32'h1111, 1'b0, 16'h5555, BYTESEL_WORD, 1'b1, 16'h1112);
    expect_txn(1, 32'h2222, 1'b0, 16'h6666, BYTESEL_WORD, 1'b1, 16'h2223);
    fork
      apply_stimulus(0, 32'h1111, 1'b0, 16'h5555, BYTESEL_WORD, 1'b1);
      begin
        for (int c = 0; c < 20 && h_bytesel == 2'b00; c++) @(negedge clk);
        check_output("grant_before_reset", h_bytesel, BYTESEL_WORD);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("reset_bytesel", h_bytesel, 0);
        check_output("reset_addr", h_addr, 0);
        check_output("reset_compl", {m1_compl, m0_compl}, 0);
        check_output("reset_init_done", init_done, 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        init_pulse = 1'b1;
        tick(1);
        init_pulse = 1'b0;
        @(negedge clk);
        check_output("reinit_done", init_done, 1);
      end
      begin
        for (int c = 0; c < 40 && rst_n; c++) @(posedge clk);
        #1;
        apply_stimulus(1, 32'h2222, 1'b0, 16'h6666, BYTESEL_WORD, 1'b1);
      end
    join

    tick(3);
    check_output("host_queue_drained", hq.size(), 0);
    check_output("compl_queue_drained", cq.size(), 0);
    check_output("fixed_queue_drained", fq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Two-requester arbiter sharing the single host port of sdram_controller, e.g. instruction fetch on port 0 and data/DMA on port 1. It waits for controller initialisation, then grants the port to one requester at a time with round-robin fairness. It forwards address, data, write-enable and bytesel to the controller and routes completion back to the granted requester only. It sits between the CPU bus bridges and sdram_controller.

Parameters:
ADDR_WIDTH, 32, width of h_addr and requester addresses
DATA_WIDTH, 16, width of write/read data
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
m0_addr  in  ADDR_WIDTH  port 0 address
m0_wr_en  in  1  port 0 write (1) / read (0)
m0_bytesel  in  2  port 0 byte lanes; nonzero = request pending
m0_wdata  in  DATA_WIDTH  port 0 write data
m0_rdata  out  DATA_WIDTH  port 0 read data
m0_compl  out  1  port 0 completion pulse
m1_addr, m1_wr_en, m1_bytesel, m1_wdata, m1_rdata, m1_compl  (same as port 0, for port 1)
h_addr  out  ADDR_WIDTH  to controller
h_wr_en  out  1  to controller
h_bytesel  out  2  to controller
h_wdata  out  DATA_WIDTH  to controller
h_rdata  in  DATA_WIDTH  from controller
h_compl  in  1  from controller, one-cycle pulse
init_done  out  1  controller initialisation finished

Behaviour:
- Requester protocol: request = mN_bytesel != 0. The requester holds addr/wr_en/wdata/bytesel stable until mN_compl. It may drop the request in the compl cycle.
- States: INIT, IDLE, GRANT, RELEASE. Registered state, grant index gnt and last-served index last.
- Reset (async, any time): state=INIT, gnt=0, last=1, init_done=0. All h_* outputs are 0 and m*_compl=0 while not in GRANT.
- INIT: h_bytesel=0. The first h_compl moves the block to IDLE and sets init_done=1, which is sticky until reset. Requests are ignored and never acknowledged in INIT.
- IDLE: h_* outputs are 0.
  - Only one port requesting: gnt<=that port.
  - Both requesting: with FIXED_PRIO=0, gnt<=~last; with FIXED_PRIO=1, gnt<=0.
  - Any grant moves the block to GRANT. No request: remain in IDLE.
- GRANT: h_addr/h_wr_en/h_wdata/h_bytesel are combinationally muxed from port gnt. mgnt_compl=h_compl; the other port's compl is 0.
  - On h_compl, h_bytesel is forced to 00 in that same cycle, last<=gnt, and the block moves to RELEASE.
- RELEASE: one cycle with h_bytesel=0 so the controller sees idle between transactions. Then IDLE.
- Latency: a request first seen in IDLE at edge k is driven to the controller from cycle k+1. Back-to-back transactions from one port have a minimum 2-cycle gap (RELEASE + IDLE).
- m0_rdata and m1_rdata both equal h_rdata unconditionally. Each is valid only with its compl.
- Requester drops bytesel while granted (protocol violation): h_bytesel follows to 0. The block stays in GRANT until h_compl.
- h_compl in IDLE or RELEASE: ignored, no compl to any port.
- Reset mid-GRANT: outputs go to 0 immediately and the block returns to INIT. System reset also resets the controller, whose init completion re-enters IDLE.
- No starvation: with FIXED_PRIO=0 and both ports continuously requesting, grants strictly alternate.

Decomposition:
- Shared package sdram_pkg holds:
  - state encodings ARB_INIT=2'b00, ARB_IDLE=2'b01, ARB_GRANT=2'b11, ARB_RELEASE=2'b10;
  - BYTESEL_NONE=2'b00 and BYTESEL_WORD=2'b11;
  - ADDR_WIDTH/DATA_WIDTH defaults.
- One natural sub-module: sdram_rr_pick, the combinational two-way round-robin/fixed-priority selector (req[1:0], last, fixed -> gnt, valid).
- The mux and FSM stay in sdram_arbiter.

Test Plan:
- Reset, then a controller init h_compl at cycle 10 -> init_done=1 from cycle 11. A m0 request with bytesel 11 made before that pulse is not forwarded (h_bytesel=00) until after it.
- m0 write, addr 0x00000010, wdata 0x0011 -> h_addr=0x10, h_wdata=0x0011, h_wr_en=1, h_bytesel=11 one cycle after the request. m0_compl pulses with h_compl; m1_compl stays 0.
- m0 and m1 both request reads continuously with FIXED_PRIO=0 and last=1 -> grant order 0,1,0,1. Each port sees exactly one compl per transaction, and a RELEASE cycle with h_bytesel=00 precedes every regrant.
- Same as above with FIXED_PRIO=1 -> port 0 served every time; port 1 granted only on a cycle where m0_bytesel=00.
- Full sweep: m0 writes the address+1 pattern to 0x0000–0xfffe, then m1 reads it back (controller and memory model behind the arbiter) -> every m1_rdata equals addr+1.
- rst_n asserted mid-GRANT -> h_bytesel=00 and compl=0 immediately, init_done=0. After the next h_compl, normal operation resumes.
